// File: rtl/crc32_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | crc32_pkg : shared types and constants for the crc32 job sequencer |
// | Revision  : 1.0                                                    |
// +------------------------------------------------------------------+
package crc32_pkg;

   typedef logic [31:0] crc_word_t;

   typedef struct packed {
      crc_word_t message;
      crc_word_t polynomial;
   } crc_job_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      COMPUTE = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4
   } ctrl_state_e;

   localparam crc_word_t CRC32_POLY_LSB_FIRST = 32'hEDB88320;

endpackage
`default_nettype wire

// File: rtl/crc32_job_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | crc32_job_ctrl_if : job request and result streams                 |
// | Revision          : 1.0                                            |
// +------------------------------------------------------------------+
interface crc32_job_ctrl_if;
   import crc32_pkg::*;

   logic      job_valid_i;
   logic      job_ready_o;
   crc_word_t job_message_i;
   crc_word_t job_polynomial_i;
   logic      res_valid_o;
   logic      res_ready_i;
   crc_word_t res_crc_o;

   modport master (
      output job_valid_i, job_message_i, job_polynomial_i, res_ready_i,
      input  job_ready_o, res_valid_o, res_crc_o
   );

   modport slave (
      input  job_valid_i, job_message_i, job_polynomial_i, res_ready_i,
      output job_ready_o, res_valid_o, res_crc_o
   );
endinterface
`default_nettype wire

// File: rtl/crc_job_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | crc_job_fifo : synchronous job FIFO with registered full/empty     |
// | Revision     : 1.0                                                 |
// +------------------------------------------------------------------+
module crc_job_fifo
   import crc32_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     push_i,
   input  crc_job_t push_data_i,
   input  logic     pop_i,
   output crc_job_t pop_data_o,
   output logic     full_o,
   output logic     empty_o
);
   localparam int AW = $clog2(DEPTH);

   crc_job_t      mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          do_push, do_pop;

   // Gating on registered flags means a same-cycle push never reaches the reader.
   always_comb begin
      do_push  = push_i && !full_q;
      do_pop   = pop_i && !empty_q;
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      full_d   = (count_d == (AW+1)'(DEPTH));
      empty_d  = (count_d == '0);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign pop_data_o = mem_q[rd_ptr_q];
   assign full_o     = full_q;
   assign empty_o    = empty_q;

endmodule
`default_nettype wire

// File: rtl/crc32_job_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | crc32_job_ctrl : sequences buffered jobs through the serial crc32  |
// | Revision       : 1.0                                               |
// +------------------------------------------------------------------+
module crc32_job_ctrl
   import crc32_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int COMPUTE_CYCLES = 33
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   crc32_job_ctrl_if.slave        bus,
   output logic                   busy_o,
   output logic                   core_rst_no,
   output logic                   core_compute_o,
   output crc_word_t              core_message_o,
   output crc_word_t              core_polynomial_o,
   input  crc_word_t              core_crc_i
);
   localparam int CW = $clog2(COMPUTE_CYCLES);

   localparam logic [2:0] S_IDLE    = IDLE;
   localparam logic [2:0] S_LOAD    = LOAD;
   localparam logic [2:0] S_COMPUTE = COMPUTE;
   localparam logic [2:0] S_CAPTURE = CAPTURE;
   localparam logic [2:0] S_DONE    = DONE;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          core_rst_q, core_rst_d;
   logic          compute_q, compute_d;
   crc_word_t     msg_q, msg_d;
   crc_word_t     poly_q, poly_d;
   logic          res_valid_q, res_valid_d;
   crc_word_t     res_crc_q, res_crc_d;

   crc_job_t      fifo_push_data, fifo_pop_data;
   logic          fifo_pop, fifo_full, fifo_empty;

   assign fifo_push_data = '{message: bus.job_message_i, polynomial: bus.job_polynomial_i};

   crc_job_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (bus.job_valid_i),
      .push_data_i (fifo_push_data),
      .pop_i       (fifo_pop),
      .pop_data_o  (fifo_pop_data),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      core_rst_d  = core_rst_q;
      compute_d   = compute_q;
      msg_d       = msg_q;
      poly_d      = poly_q;
      res_valid_d = res_valid_q;
      res_crc_d   = res_crc_q;
      fifo_pop    = 1'b0;
      case (state_q)
         S_IDLE: begin
            core_rst_d = 1'b1;
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               msg_d      = fifo_pop_data.message;
               poly_d     = fifo_pop_data.polynomial;
               core_rst_d = 1'b0;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            core_rst_d = 1'b1;
            compute_d  = 1'b1;
            cnt_d      = CW'(COMPUTE_CYCLES - 1);
            state_d    = S_COMPUTE;
         end
         S_COMPUTE: begin
            if (cnt_q == '0) begin
               compute_d = 1'b0;
               state_d   = S_CAPTURE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_CAPTURE: begin
            res_crc_d   = core_crc_i;
            res_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            // Chain straight into the next load so back-to-back jobs skip IDLE.
            if (res_valid_q && bus.res_ready_i) begin
               res_valid_d = 1'b0;
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  msg_d      = fifo_pop_data.message;
                  poly_d     = fifo_pop_data.polynomial;
                  core_rst_d = 1'b0;
                  state_d    = S_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         core_rst_q  <= 1'b0;
         compute_q   <= 1'b0;
         msg_q       <= '0;
         poly_q      <= '0;
         res_valid_q <= 1'b0;
         res_crc_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         core_rst_q  <= core_rst_d;
         compute_q   <= compute_d;
         msg_q       <= msg_d;
         poly_q      <= poly_d;
         res_valid_q <= res_valid_d;
         res_crc_q   <= res_crc_d;
      end
   end

   assign bus.job_ready_o = rst_i && !fifo_full;
   assign bus.res_valid_o = res_valid_q;
   assign bus.res_crc_o   = res_crc_q;
   assign busy_o            = (state_q != S_IDLE) || !fifo_empty;
   assign core_rst_no       = core_rst_q;
   assign core_compute_o    = compute_q;
   assign core_message_o    = msg_q;
   assign core_polynomial_o = poly_q;

endmodule
`default_nettype wire

// File: tb/tb_crc32_job_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_crc32_job_ctrl : scoreboard bench with a bit-serial core model  |
// | Revision          : 1.0                                            |
// +------------------------------------------------------------------+
module tb_crc32_job_ctrl;
   import crc32_pkg::*;

   logic      clk = 1'b0;
   logic      rst_n;
   logic      busy, core_rst_n, core_compute;
   crc_word_t core_msg, core_poly, core_crc;

   always #5 clk = ~clk;

   crc32_job_ctrl_if bus();

   crc32_job_ctrl #(.FIFO_DEPTH(4), .COMPUTE_CYCLES(33)) dut (
      .clk_i             (clk),
      .rst_i             (rst_n),
      .bus               (bus),
      .busy_o            (busy),
      .core_rst_no       (core_rst_n),
      .core_compute_o    (core_compute),
      .core_message_o    (core_msg),
      .core_polynomial_o (core_poly),
      .core_crc_i        (core_crc)
   );

   // Core model: loads on reset low, 32 division steps while counting 63..32, then holds.
   logic [63:0] core_r;
   int          core_cnt;

   function automatic crc_word_t rev32(input crc_word_t x);
      crc_word_t r;
      for (int i = 0; i < 32; i++) r[i] = x[31-i];
      return r;
   endfunction

   function automatic logic [63:0] div_step(input logic [63:0] r, input crc_word_t p);
      logic [63:0] n;
      n = r << 1;
      if (r[63]) n[63:32] = n[63:32] ^ p;
      return n;
   endfunction

   always @(posedge clk) begin
      if (!core_rst_n) begin
         core_r   <= {core_msg, 32'h0};
         core_cnt <= 63;
      end else if (core_compute && core_cnt > 31) begin
         core_r   <= div_step(core_r, rev32(core_poly));
         core_cnt <= core_cnt - 1;
      end
   end
   assign core_crc = core_r[63:32];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int        checks = 0, failures = 0;
   crc_word_t exp_q[$];
   int        hs_count = 0;
   int        exp_rise = -1;
   bit        b2b_mode = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor
   bit        prev_valid = 1'b0, prev_ready = 1'b0;
   crc_word_t prev_crc = '0;
   int        comp_cnt = 0;
   int        last_rise = -100, last_hs = -200;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
         prev_ready = 1'b0;
         comp_cnt   = 0;
      end else begin
         if (core_compute) comp_cnt++;
         if (bus.res_valid_o && !prev_valid) begin
            chk("compute_cycles", comp_cnt, 33);
            comp_cnt = 0;
            if (exp_rise >= 0) begin
               chk("latency", cyc, exp_rise);
               exp_rise = -1;
            end
            if (b2b_mode && last_hs == last_rise) chk("b2b_spacing", cyc - last_rise, 36);
            last_rise = cyc;
         end
         if (prev_valid && !prev_ready) begin
            chk("valid_held", {31'h0, bus.res_valid_o}, 32'h1);
            chk("crc_held", bus.res_crc_o, prev_crc);
         end
         if (bus.res_valid_o && bus.res_ready_i) begin
            hs_count++;
            last_hs = cyc;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result: got 0x%08h expected none", bus.res_crc_o);
            end else begin
               chk("res_crc", bus.res_crc_o, exp_q.pop_front());
            end
         end
         prev_valid = bus.res_valid_o;
         prev_ready = bus.res_ready_i;
         prev_crc   = bus.res_crc_o;
      end
   end

   task automatic push_job(input crc_word_t msg, input crc_word_t exp, output int c0);
      bit r;
      int n;
      n = 0;
      @(posedge clk); #1;
      bus.job_valid_i      = 1'b1;
      bus.job_message_i    = msg;
      bus.job_polynomial_i = CRC32_POLY_LSB_FIRST;
      forever begin
         @(negedge clk) r = bus.job_ready_o;
         @(posedge clk);
         if (r) break;
         n++;
         if (n > 2000) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: got no accept expected accept of 0x%08h", msg);
            break;
         end
      end
      #1;
      c0 = cyc;
      bus.job_valid_i = 1'b0;
      if (n <= 2000) exp_q.push_back(exp);
   endtask

   task automatic wait_hs(input int target, input int bound);
      int n;
      n = 0;
      while (hs_count < target && n < bound) begin
         @(posedge clk); #1;
         n++;
      end
      if (hs_count < target) begin
         checks++;
         failures++;
         $display("FAIL hs_timeout: got %0d handshakes expected %0d", hs_count, target);
      end
   endtask

   int c0, t6, hs0, n;
   bit job6_done = 1'b0;

   initial begin
      bus.job_valid_i      = 1'b0;
      bus.job_message_i    = '0;
      bus.job_polynomial_i = '0;
      bus.res_ready_i      = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_core_rst_n", {31'h0, core_rst_n}, 32'h0);
      chk("rst_compute", {31'h0, core_compute}, 32'h0);
      chk("rst_res_valid", {31'h0, bus.res_valid_o}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_job_ready", {31'h0, bus.job_ready_o}, 32'h0);
      chk("rst_res_crc", bus.res_crc_o, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("idle_core_rst_n", {31'h0, core_rst_n}, 32'h1);
      chk("idle_compute", {31'h0, core_compute}, 32'h0);
      chk("idle_res_valid", {31'h0, bus.res_valid_o}, 32'h0);
      chk("idle_busy", {31'h0, busy}, 32'h0);
      chk("idle_job_ready", {31'h0, bus.job_ready_o}, 32'h1);

      // Single jobs with latency measured from the accepting edge
      bus.res_ready_i = 1'b1;
      push_job(32'h1, 32'h04C11DB7, c0); exp_rise = c0 + 36; wait_hs(1, 200);
      push_job(32'h2, 32'h09823B6E, c0); exp_rise = c0 + 36; wait_hs(2, 200);
      push_job(32'h0, 32'h00000000, c0); exp_rise = c0 + 36; wait_hs(3, 200);

      // Backpressure: 1 in the core plus 4 buffered fills the FIFO
      bus.res_ready_i = 1'b0;
      hs0 = hs_count;
      push_job(32'h01, 32'h04C11DB7, c0);
      push_job(32'h02, 32'h09823B6E, c0);
      push_job(32'h04, 32'h130476DC, c0);
      push_job(32'h08, 32'h2608EDB8, c0);
      push_job(32'h10, 32'h4C11DB70, c0);
      chk("full_job_ready", {31'h0, bus.job_ready_o}, 32'h0);
      chk("full_busy", {31'h0, busy}, 32'h1);
      repeat (40) @(posedge clk);
      #1;
      chk("held_valid", {31'h0, bus.res_valid_o}, 32'h1);
      chk("held_crc", bus.res_crc_o, 32'h04C11DB7);
      b2b_mode = 1'b1;
      fork
         begin
            push_job(32'h20, 32'h9823B6E0, t6);
            job6_done = 1'b1;
         end
      join_none
      repeat (20) @(posedge clk);
      #1;
      chk("sixth_held", {31'h0, job6_done}, 32'h0);
      bus.res_ready_i = 1'b1;
      wait_hs(hs0 + 6, 600);
      b2b_mode = 1'b0;

      // Reset during the 15th compute cycle with two jobs queued
      push_job(32'h1, 32'h04C11DB7, c0);
      push_job(32'h2, 32'h09823B6E, c0);
      push_job(32'h4, 32'h130476DC, c0);
      n = 0;
      while (comp_cnt < 15 && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      chk("reached_compute15", comp_cnt, 15);
      hs0 = hs_count;
      rst_n = 1'b0;
      #1;
      chk("mid_core_rst_n", {31'h0, core_rst_n}, 32'h0);
      chk("mid_compute", {31'h0, core_compute}, 32'h0);
      chk("mid_res_valid", {31'h0, bus.res_valid_o}, 32'h0);
      chk("mid_busy", {31'h0, busy}, 32'h0);
      chk("mid_job_ready", {31'h0, bus.job_ready_o}, 32'h0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      chk("post_rst_no_result", hs_count, hs0);
      chk("post_rst_busy", {31'h0, busy}, 32'h0);

      // Random downstream backpressure
      hs0 = hs_count;
      fork
         begin
            push_job(32'h03, 32'h0D4326D9, c0);
            push_job(32'h40, 32'h34867077, c0);
            push_job(32'h80, 32'h690CE0EE, c0);
         end
         begin
            n = 0;
            while (hs_count < hs0 + 3 && n < 3000) begin
               @(posedge clk); #1;
               bus.res_ready_i = 1'($urandom_range(0, 1));
               n++;
            end
            bus.res_ready_i = 1'b1;
         end
      join
      repeat (50) @(posedge clk);
      #1;
      chk("rand_handshakes", hs_count, hs0 + 3);
      chk("final_queue_empty", exp_q.size(), 0);
      chk("final_busy", {31'h0, busy}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/crc32_job_ctrl.md
Name: crc32_job_ctrl

Overview:
- Upstream sequencer for the bit-serial crc32 core.
- Accepts (message, polynomial) jobs on a valid/ready stream and buffers them in a small FIFO.
- For each job it drives the core's load-by-reset, compute enable and message/polynomial inputs, then captures the 32-bit result.
- Presents the result downstream on a valid/ready stream, isolating the rest of the SoC from the core's reset-load protocol.

Parameters:
- FIFO_DEPTH, 4, job buffer entries; power of two, ≥2.
- COMPUTE_CYCLES, 33, number of clock edges with core compute high (count 63 down to 31 inclusive).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-low
- job_valid_i  in  1  job offered
- job_ready_o  out  1  FIFO not full
- job_message_i  in  32  message word
- job_polynomial_i  in  32  polynomial, LSB-first (core reverses internally)
- res_valid_o  out  1  result available
- res_ready_i  in  1  downstream accepts result
- res_crc_o  out  32  captured CRC
- busy_o  out  1  FSM not IDLE or FIFO non-empty
- core_rst_no  out  1  to core rst_i (active-low load/reset)
- core_compute_o  out  1  to core compute_i
- core_message_o  out  32  to core message_i
- core_polynomial_o  out  32  to core polynomial_i
- core_crc_i  in  32  from core message_o

Behaviour:
- Reset (rst_i low, async): FIFO emptied; FSM=IDLE; core_rst_no=0 (core held in reset); core_compute_o=0; core_message_o/core_polynomial_o=0; res_valid_o=0; res_crc_o=0; busy_o=0; job_ready_o=0 while rst_i low, 1 after.
- All core_* outputs are registered; no combinational path from inputs to core_rst_no or core_compute_o.
- Job push: when job_valid_i && job_ready_o at an edge; job_ready_o = !full.
- Push and pop in the same cycle:
  - FIFO full: push is refused, since job_ready_o is based on registered full.
  - FIFO empty: the pushed job is not visible until the next cycle (no bypass).
- FSM states:
  - IDLE: core_rst_no=1. If FIFO non-empty: pop, register message/poly onto core_message_o/core_polynomial_o, drive core_rst_no=0 → LOAD.
  - LOAD: exactly 1 cycle with core_rst_no=0 and operands stable. Next edge: core_rst_no=1, core_compute_o=1, cycle counter=COMPUTE_CYCLES-1 → COMPUTE.
  - COMPUTE: core_compute_o stays high for exactly COMPUTE_CYCLES sampling edges. Counter decrements each edge; at counter==0, drop core_compute_o → CAPTURE.
  - CAPTURE: 1 cycle. At its closing edge: res_crc_o<=core_crc_i, res_valid_o<=1 → DONE.
  - DONE: hold res_crc_o and res_valid_o. On res_valid_o && res_ready_i: clear res_valid_o; if FIFO non-empty, pop and go directly to LOAD (same actions as IDLE), else → IDLE.
- core_message_o/core_polynomial_o hold stable from LOAD through CAPTURE.
- Latency:
  - Job accepted at edge E0 with FIFO empty and FSM IDLE: res_valid_o rises after edge E0+36.
  - Back-to-back with res_ready_i tied 1: one result every 36 cycles.
- res_crc_o changes only at CAPTURE; it is stable while res_valid_o && !res_ready_i (backpressure holds the FSM in DONE, FIFO keeps filling).
- busy_o = (state!=IDLE) || !empty.
- Reset mid-operation: everything returns to reset values immediately; partially computed result is discarded; queued jobs are lost.

Decomposition:
- Package crc32_pkg:
  - typedef crc_word_t (logic [31:0]).
  - typedef struct crc_job_t {message, polynomial}.
  - enum ctrl_state_e {IDLE, LOAD, COMPUTE, CAPTURE, DONE}.
  - constant CRC32_POLY_LSB_FIRST = 32'hEDB88320.
- One sub-module: crc_job_fifo.
  - Synchronous FIFO of crc_job_t, parameter DEPTH.
  - Ports: push/pop/full/empty, async active-low reset, registered flags.

Test Plan:
- Reset, then idle 10 cycles -> core_rst_no=1, core_compute_o=0, res_valid_o=0, busy_o=0, job_ready_o=1.
- Job {msg=0x00000001, poly=0xEDB88320}, res_ready_i=1 -> core_compute_o high exactly 33 cycles; res_valid_o after E0+36; res_crc_o=0x04C11DB7.
- Job {0x00000002, 0xEDB88320} -> res_crc_o=0x09823B6E; job {0x00000000, 0xEDB88320} -> res_crc_o=0x00000000.
- Push 6 jobs with res_ready_i=0:
  - job_ready_o falls after 5 accepted (4 in FIFO plus 1 in core); the 6th is held.
  - First result is held stable.
  - Release res_ready_i -> all 6 results appear in order, 36 cycles apart.
- Assert rst_i low at the 15th COMPUTE cycle with 2 jobs queued -> core_rst_no=0 immediately, res_valid_o=0, FIFO empty; no result emerges after release.
- Job with res_ready_i toggling randomly -> res_crc_o never changes while res_valid_o && !res_ready_i; exactly one handshake per job.
